// File: rtl/md_issue_ctrl.sv
// Issue/sequencing controller for the iterative multiply/divide unit: captures an
// X-stage mult/div op, pulses the unit's start, stalls the front end, and hands one result to P/W.
module md_issue_ctrl #(
  parameter int MAX_CYCLES = 40,
  parameter int CNT_W      = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_valid,
  input  logic [31:0] i_insn,
  input  logic        i_is_mult,
  input  logic        i_is_div,
  input  logic [31:0] i_opA,
  input  logic [31:0] i_opB,
  input  logic        i_flush,
  input  logic        md_rdy,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  output logic        o_ctrl_mult,
  output logic        o_ctrl_div,
  output logic [31:0] o_opA,
  output logic [31:0] o_opB,
  output logic        o_stall,
  output logic [31:0] o_insn,
  output logic [31:0] o_result,
  output logic        o_MD_rdy,
  output logic        o_exception,
  output logic        o_timeout,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      insn_q;
  logic             is_md;
  logic             start;
  logic             accept;
  logic             wd_hit;
  logic             op_end;
  logic             finish;

  assign is_md  = i_is_mult | i_is_div;
  assign start  = i_valid & is_md & ~i_flush;
  assign accept = start & ((state == S_IDLE) | (state == S_DONE));
  // cnt is 0 in the start-pulse cycle, so CNT_LAST marks the MAX_CYCLES-th cycle of waiting.
  assign wd_hit = ((state == S_BUSY) | (state == S_DRAIN)) & (cnt == CNT_LAST);
  assign op_end = md_rdy | wd_hit;
  assign finish = (state == S_BUSY) & ~i_flush & op_end;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = S_BUSY;
      S_BUSY: begin
        // Flush beats a coincident result: the op is dead, nothing left to drain.
        if (i_flush)     state_nx = op_end ? S_IDLE : S_DRAIN;
        else if (op_end) state_nx = S_DONE;
      end
      S_DONE:  state_nx = accept ? S_BUSY : S_IDLE;
      S_DRAIN: if (op_end) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_stall   = ((state == S_IDLE) & start) | (state == S_BUSY) |
                ((state == S_DRAIN) & i_valid & is_md);
    dbg_state = state;
  end

  // Datapath registers: capture on accept, single-cycle result presentation
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt         <= '0;
      insn_q      <= '0;
      o_opA       <= '0;
      o_opB       <= '0;
      o_ctrl_mult <= 1'b0;
      o_ctrl_div  <= 1'b0;
      o_insn      <= '0;
      o_result    <= '0;
      o_MD_rdy    <= 1'b0;
      o_exception <= 1'b0;
      o_timeout   <= 1'b0;
    end else begin
      o_ctrl_mult <= accept & i_is_mult;
      o_ctrl_div  <= accept & ~i_is_mult & i_is_div;
      if (accept) begin
        cnt    <= '0;
        insn_q <= i_insn;
        o_opA  <= i_opA;
        o_opB  <= i_opB;
      end else if ((state == S_BUSY) | (state == S_DRAIN)) begin
        cnt <= cnt + CNT_W'(1);
      end
      o_MD_rdy    <= finish;
      o_insn      <= finish ? insn_q : 32'd0;
      o_result    <= (finish & md_rdy) ? md_result : 32'd0;
      o_exception <= finish & (md_rdy ? md_exception : 1'b1);
      o_timeout   <= finish & ~md_rdy;
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Bench for md_issue_ctrl: table-driven ops with a result scoreboard, plus
// hand-written back-to-back, flush, watchdog and reset sequences.
module tb_md_issue_ctrl;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;
  localparam int W = 66;

  logic        clk;
  logic        reset;
  logic        i_valid;
  logic [31:0] i_insn;
  logic        i_is_mult;
  logic        i_is_div;
  logic [31:0] i_opA;
  logic [31:0] i_opB;
  logic        i_flush;
  logic        md_rdy;
  logic [31:0] md_result;
  logic        md_exception;
  logic        o_ctrl_mult;
  logic        o_ctrl_div;
  logic [31:0] o_opA;
  logic [31:0] o_opB;
  logic        o_stall;
  logic [31:0] o_insn;
  logic [31:0] o_result;
  logic        o_MD_rdy;
  logic        o_exception;
  logic        o_timeout;
  logic [1:0]  dbg_state;

  md_issue_ctrl #(.MAX_CYCLES(8), .CNT_W(4)) dut (
    .clock(clk), .reset(reset), .i_valid(i_valid), .i_insn(i_insn),
    .i_is_mult(i_is_mult), .i_is_div(i_is_div), .i_opA(i_opA), .i_opB(i_opB),
    .i_flush(i_flush), .md_rdy(md_rdy), .md_result(md_result),
    .md_exception(md_exception), .o_ctrl_mult(o_ctrl_mult), .o_ctrl_div(o_ctrl_div),
    .o_opA(o_opA), .o_opB(o_opB), .o_stall(o_stall), .o_insn(o_insn),
    .o_result(o_result), .o_MD_rdy(o_MD_rdy), .o_exception(o_exception),
    .o_timeout(o_timeout), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: {insn, result, exception, timeout}
  logic [W-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_bad  = 0;
  int n_mult = 0;
  int n_div  = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (o_ctrl_mult) n_mult++;
      if (o_ctrl_div)  n_div++;
      if (o_MD_rdy) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_md_rdy: got insn %h result %h expected no output", o_insn, o_result);
        end else begin
          chk("md_out", {o_insn, o_result, o_exception, o_timeout}, exp_q.pop_front());
        end
      end else begin
        chk("bubble", W'({o_insn, o_result, o_exception, o_timeout}), '0);
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_valid = 0; i_is_mult = 0; i_is_div = 0; i_flush = 0;
    md_rdy = 0; md_exception = 0;
  endtask

  task automatic drive_op(input logic m, input logic d, input logic [31:0] insn,
                          input logic [31:0] a, input logic [31:0] b);
    i_valid = 1; i_is_mult = m; i_is_div = d; i_insn = insn; i_opA = a; i_opB = b;
  endtask

  typedef struct {
    logic        m;
    logic        d;
    logic [31:0] insn;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;     // cycles from accept to md_rdy
    logic [31:0] res;
    logic        exc;
    int          e_mult;
    int          e_div;
    int          e_stall;
  } vec_t;

  vec_t vecs[5];

  // One op: accept at cycle 0, md_rdy at cycle lat, DONE at lat+1, IDLE at lat+2
  task automatic run_op(input vec_t v);
    int m0, d0, st;
    m0 = n_mult; d0 = n_div; st = 0;
    drive_op(v.m, v.d, v.insn, v.a, v.b);
    exp_q.push_back({v.insn, v.res, v.exc, 1'b0});
    #1;
    if (o_stall) st++;
    step();
    idle_inputs();
    i_opA = $urandom; i_opB = $urandom; i_insn = $urandom;
    #1;
    chk("op_capture", W'({o_opA, o_opB}), W'({v.a, v.b}));
    chk("busy_state", W'(dbg_state), W'(S_BUSY));
    for (int c = 1; c <= v.lat; c++) begin
      md_result = $urandom;
      if (c == v.lat) begin
        md_rdy = 1; md_result = v.res; md_exception = v.exc;
      end
      #1;
      if (o_stall) st++;
      step();
      md_rdy = 0; md_exception = 0;
    end
    #1;
    if (o_stall) st++;
    chk("done_state", W'(dbg_state), W'(S_DONE));
    step();
    #1;
    chk("post_idle", W'({dbg_state, o_MD_rdy, o_exception, o_timeout}), W'({S_IDLE, 3'b000}));
    chk("stall_cycles", W'(st), W'(v.e_stall));
    chk("mult_pulses", W'(n_mult - m0), W'(v.e_mult));
    chk("div_pulses", W'(n_div - d0), W'(v.e_div));
  endtask

  initial begin
    idle_inputs();
    i_insn = 0; i_opA = 0; i_opB = 0; md_result = 0;
    reset = 1;

    vecs[0] = '{1, 0, 32'h0003_8018, 32'd25, 32'd125, 3, 32'h0000_0C35, 0, 1, 0, 4};
    vecs[1] = '{0, 1, 32'h0003_801A, $urandom, 32'd0, 2, 32'hDEAD_BEEF, 1, 0, 1, 3};
    vecs[2] = '{1, 1, 32'h00A5_0018, $urandom, $urandom, 1, $urandom, 0, 1, 0, 2};
    vecs[3] = '{0, 1, 32'h00C7_001B, $urandom, $urandom, 8, $urandom, 0, 0, 1, 9};
    vecs[4] = '{1, 0, 32'h0124_0019, $urandom, $urandom, 5, $urandom, 0, 1, 0, 6};

    step();
    step();
    chk("rst_ctrl", W'({o_ctrl_mult, o_ctrl_div, o_MD_rdy, o_exception, o_timeout, o_stall, dbg_state}), '0);
    chk("rst_ops", W'({o_opA, o_opB}), '0);
    chk("rst_out", W'({o_insn, o_result}), '0);
    reset = 0;
    step();

    for (int i = 0; i < 5; i++) run_op(vecs[i]);

    // Back-to-back: div accepted during the mult's DONE cycle
    drive_op(1, 0, 32'h1111_0018, 32'd3, 32'd4);
    exp_q.push_back({32'h1111_0018, 32'd12, 1'b0, 1'b0});
    step();
    idle_inputs();
    step();
    step();
    md_rdy = 1; md_result = 32'd12;
    step();
    idle_inputs();
    drive_op(0, 1, 32'h2222_001A, 32'd100, 32'd7);
    exp_q.push_back({32'h2222_001A, 32'd14, 1'b0, 1'b0});
    #1;
    chk("b2b_done_state", W'(dbg_state), W'(S_DONE));
    chk("b2b_done_nostall", W'(o_stall), '0);
    step();
    idle_inputs();
    #1;
    chk("b2b_div_pulse", W'({o_ctrl_mult, o_ctrl_div, dbg_state}), W'({2'b01, S_BUSY}));
    chk("b2b_div_ops", W'({o_opA, o_opB}), W'({32'd100, 32'd7}));
    step();
    md_rdy = 1; md_result = 32'd14;
    step();
    idle_inputs();
    step();
    step();

    // Flush at BUSY cycle 2, md_rdy at cycle 5: dropped in DRAIN
    drive_op(1, 0, 32'h3333_0018, $urandom, $urandom);
    step();
    idle_inputs();
    step();
    i_flush = 1;
    #1;
    chk("flush_busy_stall", W'(o_stall), W'(1));
    step();
    i_flush = 0;
    #1;
    chk("drain_state", W'(dbg_state), W'(S_DRAIN));
    chk("drain_nostall", W'(o_stall), '0);
    drive_op(0, 1, 32'h4444_001A, 1, 1);
    #1;
    chk("drain_req_stall", W'(o_stall), W'(1));
    idle_inputs();
    step();
    step();
    md_rdy = 1; md_result = $urandom;
    step();
    idle_inputs();
    #1;
    chk("drain_to_idle", W'(dbg_state), W'(S_IDLE));
    step();

    // Flush coincident with md_rdy: flush wins, straight to IDLE
    drive_op(0, 1, 32'h5555_001A, $urandom, $urandom);
    step();
    idle_inputs();
    i_flush = 1; md_rdy = 1; md_result = $urandom;
    step();
    idle_inputs();
    #1;
    chk("flush_rdy_idle", W'(dbg_state), W'(S_IDLE));
    step();

    // Watchdog: no md_rdy, DONE eight cycles after the start pulse
    drive_op(0, 1, 32'h6666_001B, $urandom, $urandom);
    exp_q.push_back({32'h6666_001B, 32'd0, 1'b1, 1'b1});
    step();
    idle_inputs();
    for (int c = 1; c < 8; c++) step();
    #1;
    chk("wd_not_yet", W'({o_MD_rdy, dbg_state}), W'({1'b0, S_BUSY}));
    step();
    #1;
    chk("wd_fire", W'({o_MD_rdy, o_timeout, o_exception, o_result}), W'({3'b111, 32'd0}));
    step();

    // Reset mid-BUSY, then a stale md_rdy
    drive_op(1, 0, 32'h7777_0018, $urandom, $urandom);
    step();
    idle_inputs();
    step();
    reset = 1;
    step();
    reset = 0;
    #1;
    chk("rst_busy_ctrl", W'({o_ctrl_mult, o_ctrl_div, o_MD_rdy, o_exception, o_timeout, o_stall, dbg_state}), '0);
    chk("rst_busy_data", W'({o_opA, o_opB}), '0);
    md_rdy = 1; md_result = $urandom;
    step();
    idle_inputs();
    #1;
    chk("late_rdy_ignored", W'({o_MD_rdy, dbg_state}), W'({1'b0, S_IDLE}));
    run_op(vecs[0]);

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
    chk("queue_empty", W'(exp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
